if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register. This block produces the pc/instruction pair consumed by decode.
//   - Runs a PC, fetches over a variable-latency req/ready instruction-memory port.
//   - Honours decode's hazard freeze and the execute-stage branch redirect.
//   - Flushes and discards wrong-path fetches.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset
//   PC_STEP      4              byte increment per sequential fetch
// PORTS
//   clk             in   1   single clock, all state on rising edge
//   rst             in   1   synchronous, active-high reset
//   freeze          in   1   hazard stall from decode: hold IF/ID and PC
//   branch_taken    in   1   redirect request from execute, one-cycle pulse
//   branch_address  in   32  redirect target, valid with branch_taken
//   imem_req        out  1   fetch request, held until imem_ready
//   imem_addr       out  32  fetch address, stable while imem_req=1
//   imem_ready      in   1   memory response strobe, rdata valid this cycle
//   imem_rdata      in   32  fetched word
//   pc_out          out  32  IF/ID: address of fetched instr + PC_STEP
//   instruction_out out  32  IF/ID: fetched instruction, 0 when bubble
//   valid_out       out  1   IF/ID: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//   Reset (rst=1 at edge):
//     pc=RESET_PC, state=S_FETCH, pc_out=0, instruction_out=0, valid_out=0, hold buffer empty.
//     imem_req=1 in the first cycle after reset.
//   Handshake: a request cannot be withdrawn.
//     - imem_req=1 with imem_addr=pc is held until a cycle with imem_ready=1.
//     - imem_ready is ignored when imem_req=0.
//     - Minimum latency: 1 cycle (ready in the same cycle as req).
//   States:
//     S_FETCH  imem_req=1, imem_addr=pc.
//       ready & ~freeze: IF/ID <= {pc+PC_STEP, rdata, 1}; pc <= pc+PC_STEP; stay.
//       ready & freeze: buffer <= rdata; pc <= pc+PC_STEP; IF/ID held; -> S_HOLD.
//       ~ready & ~freeze: IF/ID <= bubble (instruction_out=0, valid_out=0, pc_out unchanged).
//       ~ready & freeze: IF/ID held.
//     S_HOLD   imem_req=0.
//       freeze=1: hold everything.
//       freeze=0: IF/ID <= {pc, buffer, 1}; -> S_FETCH.
//     S_DRAIN  imem_req=1, imem_addr=old (wrong-path) address; response discarded.
//       ready: -> S_FETCH at pc (already redirected).
//       IF/ID loads bubble unless freeze=1.
//   Branch (branch_taken=1), highest priority, overrides freeze:
//     - pc <= branch_address; IF/ID <= bubble (flush); hold buffer cleared.
//     - S_FETCH & ~ready: -> S_DRAIN, latching the in-flight address for imem_addr.
//     - S_FETCH & ready, or S_HOLD: the word is dropped; -> S_FETCH at target next cycle.
//     - S_DRAIN: pc <= new target; stay in S_DRAIN.
//   Arithmetic: pc+PC_STEP is modulo 2^32 (0xFFFF_FFFC+4 wraps to 0); no alignment check.
//   Reset mid-transaction: returns to S_FETCH at RESET_PC.
//     The memory is reset on the same rst, so the outstanding response is not awaited.
//   Invariants:
//     - Only one request outstanding.
//     - No instruction is ever delivered twice or skipped, except on a branch flush.
// TESTING
//   1. Reset, ready=1 every cycle, rdata=0xE000_0000+addr
//      -> valid_out=1 from cycle 2; pc_out=4,8,12,... tracks instructions.
//   2. Latency-3 memory -> imem_addr=0 held 3 cycles.
//      -> IF/ID shows 2 bubbles, then {pc_out=4, instr(0)}.
//   3. freeze=1 for 4 cycles while ready pulses
//      -> IF/ID unchanged, state S_HOLD, imem_req=0.
//      -> Freeze drop: buffered word appears next cycle, no loss or duplicate.
//   4. branch_taken=1, target 0x100, with a fetch at 0x20 in flight (latency 3)
//      -> S_DRAIN, 0x20 data dropped.
//      -> Next request addr=0x100; first valid pc_out=0x104.
//   5. branch_taken and freeze in the same cycle, in S_HOLD
//      -> buffer discarded, valid_out=0, next imem_addr=target.
//   6. RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000;
//      rst asserted mid-S_DRAIN -> all outputs return to reset values.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, req/ready instruction-memory handshake,
// freeze/branch handling and the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] hold_buf, hold_buf_n;
    logic            req_n;
    logic [XLEN-1:0] addr_n;
    logic [XLEN-1:0] pc_out_n;
    logic [XLEN-1:0] instr_n;
    logic            valid_n;
    logic [XLEN-1:0] pc_inc;

    // State, PC, hold buffer, memory request and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FETCH;
            pc              <= RESET_PC;
            hold_buf        <= '0;
            imem_req        <= 1'b1;
            imem_addr       <= RESET_PC;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            hold_buf        <= hold_buf_n;
            imem_req        <= req_n;
            imem_addr       <= addr_n;
            pc_out          <= pc_out_n;
            instruction_out <= instr_n;
            valid_out       <= valid_n;
        end
    end

    // Next-state, next-PC and IF/ID update; a branch overrides freeze
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_buf_n = hold_buf;
        pc_out_n   = pc_out;
        instr_n    = instruction_out;
        valid_n    = valid_out;
        pc_inc     = pc + STEP;

        if (branch_taken) begin
            pc_n       = branch_address;
            instr_n    = '0;
            valid_n    = 1'b0;
            hold_buf_n = '0;
            case (state)
                S_FETCH: state_n = imem_ready ? S_FETCH : S_DRAIN;
                S_HOLD:  state_n = S_FETCH;
                S_DRAIN: state_n = imem_ready ? S_FETCH : S_DRAIN;
                default: state_n = S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_n = pc_inc;
                        if (freeze) begin
                            hold_buf_n = imem_rdata;
                            state_n    = S_HOLD;
                        end else begin
                            pc_out_n = pc_inc;
                            instr_n  = imem_rdata;
                            valid_n  = 1'b1;
                        end
                    end else if (!freeze) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        pc_out_n = pc;
                        instr_n  = hold_buf;
                        valid_n  = 1'b1;
                        state_n  = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        state_n = S_FETCH;
                    end
                    if (!freeze) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                default: state_n = S_FETCH;
            endcase
        end

        // Drain keeps presenting the wrong-path address until its response lands
        req_n  = (state_n != S_HOLD);
        addr_n = (state_n == S_DRAIN) ? imem_addr : pc_n;
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: variable-latency memory model plus a transaction-level
// reference of the fetch stream, compared every cycle.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned STEP   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    if_stage #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: next fetch address, one-word hold slot, wrong-path flag
    logic [31:0] m_pc, m_daddr, m_hword, m_pcout, m_instr;
    bit          m_hold, m_drain, m_valid;

    // Memory model state
    int lat      = 1;
    int wait_cnt = 0;
    bit rand_lat = 0;
    bit noise_en = 0;
    bit check_en = 0;
    bit expect_reset = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit f, input bit b,
                              input logic [31:0] ba, input bit rdy);
        bit got;
        if (r) begin
            m_pc = RST_PC; m_hold = 0; m_drain = 0;
            m_pcout = 0; m_instr = 0; m_valid = 0;
            return;
        end
        got = !m_hold && rdy;
        if (b) begin
            if (!m_hold && !m_drain && !got) begin
                m_drain = 1; m_daddr = m_pc;
            end else if (m_drain && got) begin
                m_drain = 0;
            end
            m_hold = 0; m_pc = ba; m_instr = 0; m_valid = 0;
        end else if (m_hold) begin
            if (!f) begin
                m_pcout = m_pc; m_instr = m_hword; m_valid = 1; m_hold = 0;
            end
        end else if (m_drain) begin
            if (got) m_drain = 0;
            if (!f) begin m_instr = 0; m_valid = 0; end
        end else if (got) begin
            if (f) begin
                m_hold = 1; m_hword = mem_word(m_pc);
            end else begin
                m_pcout = m_pc + 32'(STEP); m_instr = mem_word(m_pc); m_valid = 1;
            end
            m_pc = m_pc + 32'(STEP);
        end else if (!f) begin
            m_instr = 0; m_valid = 0;
        end
    endtask

    // One clock: compare at negedge, drive inputs, advance reference at posedge
    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba);
        bit rdy, req_s;
        @(negedge clk);
        if (check_en) begin
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            chk("instruction_out", instruction_out, m_instr);
            chk("pc_out", pc_out, m_pcout);
            chk("imem_req", 32'(imem_req), 32'(!m_hold));
            if (!m_hold) chk("imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
        end
        if (expect_reset) begin
            expect_reset = 0;
            chk("rst_pc_out", pc_out, 32'h0);
            chk("rst_instr", instruction_out, 32'h0);
            chk("rst_valid", 32'(valid_out), 32'h0);
            chk("rst_req", 32'(imem_req), 32'h1);
            chk("rst_addr", imem_addr, RST_PC);
        end
        req_s = imem_req;
        if (req_s) rdy = (wait_cnt + 1 >= lat);
        else       rdy = noise_en && ($urandom_range(0, 3) == 0);
        rst            = r;
        freeze         = f;
        branch_taken   = b;
        branch_address = ba;
        imem_ready     = rdy;
        imem_rdata     = req_s ? mem_word(imem_addr) : $urandom;
        @(posedge clk);
        model_step(r, f, b, ba, rdy);
        if (r) wait_cnt = 0;
        else if (req_s && rdy) begin
            wait_cnt = 0;
            if (rand_lat) lat = $urandom_range(1, 4);
        end else if (req_s) wait_cnt++;
        if (r) expect_reset = 1;
    endtask

    initial begin
        bit found;
        rst = 1; freeze = 0; branch_taken = 0; branch_address = 0;
        imem_ready = 0; imem_rdata = 0;

        // Reset, then single-cycle memory streaming
        step(1, 0, 0, 0);
        check_en = 1;
        lat = 1;
        repeat (6) step(0, 0, 0, 0);

        // Latency-3 memory
        lat = 3;
        repeat (9) step(0, 0, 0, 0);

        // Freeze while a response arrives, then release
        lat = 1;
        repeat (4) step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // Branch to 0x100 with a latency-3 fetch in flight
        lat = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (!m_hold && !m_drain && wait_cnt == 1) found = 1;
            else step(0, 0, 0, 0);
        end
        chk("inflight_found", 32'(found), 32'h1);
        step(0, 0, 1, 32'h0000_0100);
        repeat (8) step(0, 0, 0, 0);

        // Branch and freeze together while holding a word
        lat = 1;
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h0000_0200);
        repeat (4) step(0, 0, 0, 0);

        // PC wrap past 0xFFFF_FFFC
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (4) step(0, 0, 0, 0);

        // Reset in the middle of a drain
        lat = 4;
        step(0, 0, 1, 32'h0000_0300);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // Randomized traffic
        rand_lat = 1;
        noise_en = 1;
        for (int i = 0; i < 2000; i++) begin
            bit r, f, b;
            logic [31:0] ba;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 8);
            ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(r, f, b, ba);
        end
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
